// File: rtl/jtag_resp_pkg.sv
// jtag_resp_pkg: shared FSM state and register field offsets for the JTAG ER1/ER2 responder.
package jtag_resp_pkg;
    typedef enum logic {IDLE, REQ} state_t;
    localparam int STAT_BUSY = 0;
    localparam int STAT_OVR  = 1;
    localparam int RDATA_LSB = 2;
    localparam int ER2_W     = 16;
endpackage

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: 3-flop synchronizer for one TAP strobe, with level output and single-cycle rise pulse.
module jtag_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);
    logic [2:0] s;
    always_ff @(posedge clk or posedge rst)
        if (rst) s <= '0;
        else     s <= {s[1:0], d};
    assign q    = s[1];
    assign rise = s[1] & ~s[2];
endmodule

// File: rtl/jtag_er1_responder.sv
// jtag_er1_responder: ER1 shift register bridging JTAG user-register scans to single-beat bus requests.
// Optional 16-bit read-only ER2 status register enabled by defining JTAG_ER2_STATUS_EN.
module jtag_er1_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    localparam int DR_W  = 1 + ADDR_W + DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              jtck_i,
    input  logic              jtdi_i,
    input  logic              jshift_i,
    input  logic              jupdate_i,
    input  logic              jrstn_i,
    input  logic              jce1_i,
    input  logic              jce2_i,
    output logic              jtdo1_o,
    output logic              jtdo2_o,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] rdata_i
);
    import jtag_resp_pkg::*;

    logic tck_r, upd_r, tdi, shift, trst_n, ce1, ce2;
    jtag_sync_edge u_tck (.clk(clk_i), .rst(rst_i), .d(jtck_i),    .q(),       .rise(tck_r));
    jtag_sync_edge u_upd (.clk(clk_i), .rst(rst_i), .d(jupdate_i), .q(),       .rise(upd_r));
    jtag_sync_edge u_tdi (.clk(clk_i), .rst(rst_i), .d(jtdi_i),    .q(tdi),    .rise());
    jtag_sync_edge u_sh  (.clk(clk_i), .rst(rst_i), .d(jshift_i),  .q(shift),  .rise());
    jtag_sync_edge u_rst (.clk(clk_i), .rst(rst_i), .d(jrstn_i),   .q(trst_n), .rise());
    jtag_sync_edge u_ce1 (.clk(clk_i), .rst(rst_i), .d(jce1_i),    .q(ce1),    .rise());
    jtag_sync_edge u_ce2 (.clk(clk_i), .rst(rst_i), .d(jce2_i),    .q(ce2),    .rise());

    state_t            state, state_nxt;
    logic [DR_W-1:0]   sr, cap_v;
    logic [DATA_W-1:0] rdata_q;
    logic              ovr, er1_sel, upd, busy, done, accept, cap1, sh1;

    assign busy   = state != IDLE;
    assign done   = busy & ack_i;
    assign accept = upd & (~busy | ack_i);
    assign cap1   = tck_r & ce1 & ~shift;
    assign sh1    = tck_r & ce1 & shift;

    always_comb begin
        cap_v                       = '0;
        cap_v[STAT_BUSY]            = busy;
        cap_v[STAT_OVR]             = ovr;
        cap_v[RDATA_LSB +: DATA_W]  = rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;

    // An update coinciding with ack starts the next command instead of dropping it.
    always_comb state_nxt = busy ? ((ack_i & ~upd) ? IDLE : REQ) : (upd ? REQ : IDLE);

    always_comb req_o = busy;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            sr                      <= '0;
            ovr                     <= 1'b0;
            rdata_q                 <= '0;
            er1_sel                 <= 1'b0;
            upd                     <= 1'b0;
            jtdo1_o                 <= 1'b0;
            {we_o, addr_o, wdata_o} <= '0;
        end else begin
            upd     <= upd_r & er1_sel;
            jtdo1_o <= sr[0];
            if (tck_r & ~shift & (ce1 | ce2)) er1_sel <= ce1;
            if (!trst_n)   sr <= '0;
            else if (cap1) sr <= cap_v;
            else if (sh1)  sr <= {tdi, sr[DR_W-1:1]};
            if (!trst_n || cap1)        ovr <= 1'b0;
            else if (upd & busy & ~ack_i) ovr <= 1'b1;
            if (accept) {we_o, addr_o, wdata_o} <= sr;
            if (done & ~we_o) rdata_q <= rdata_i;
        end

`ifdef JTAG_ER2_STATUS_EN
    logic [ER2_W-1:0] sr2;
    logic [7:0]       txn;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            sr2     <= '0;
            txn     <= '0;
            jtdo2_o <= 1'b0;
        end else begin
            if (done) txn <= txn + 8'd1;
            if (tck_r & ce2 & ~shift)     sr2 <= {txn, 6'd0, ovr, busy};
            else if (tck_r & ce2 & shift) sr2 <= {tdi, sr2[ER2_W-1:1]};
            jtdo2_o <= sr2[0];
        end
`else
    assign jtdo2_o = 1'b0;
`endif
endmodule

// File: tb/tb_jtag_er1_responder.sv
// tb_jtag_er1_responder: directed scans against hand-computed ER1/ER2 contents and bus handshakes.
module tb_jtag_er1_responder;
    logic clk = 0, rst_i = 1;
    logic jtck_i = 0, jtdi_i = 0, jshift_i = 0, jupdate_i = 0, jrstn_i = 1, jce1_i = 0, jce2_i = 0;
    logic jtdo1_o, jtdo2_o, req_o, we_o, ack_i = 0;
    logic [7:0] addr_o, wdata_o, rdata_i = 0;
    logic [16:0] dout;
    int n_chk = 0, n_pass = 0;

    jtag_er1_responder dut (
        .clk_i(clk), .rst_i(rst_i), .jtck_i(jtck_i), .jtdi_i(jtdi_i), .jshift_i(jshift_i),
        .jupdate_i(jupdate_i), .jrstn_i(jrstn_i), .jce1_i(jce1_i), .jce2_i(jce2_i),
        .jtdo1_o(jtdo1_o), .jtdo2_o(jtdo2_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .ack_i(ack_i), .rdata_i(rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic jtck_pulse();
        repeat (3) @(negedge clk);
        jtck_i = 1;
        repeat (5) @(negedge clk);
        jtck_i = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic scan(input int sel, input logic [16:0] din, input int nbits, input bit cap,
                        output logic [16:0] d);
        d = '0;
        jce1_i = (sel == 1);
        jce2_i = (sel == 2);
        if (cap) begin
            jshift_i = 0;
            jtck_pulse();
        end
        for (int i = 0; i < nbits; i++) begin
            jshift_i = 1;
            jtdi_i = din[i];
            d[i] = (sel == 2) ? jtdo2_o : jtdo1_o;
            jtck_pulse();
        end
        jshift_i = 0;
        jce1_i = 0;
        jce2_i = 0;
    endtask

    task automatic update();
        @(negedge clk) jupdate_i = 1;
        repeat (6) @(negedge clk);
        jupdate_i = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 50 && !req_o; k++) @(negedge clk);
        chk(tag, req_o, 1);
    endtask

    task automatic ack(input logic [7:0] d);
        @(negedge clk);
        ack_i = 1;
        rdata_i = d;
        @(negedge clk);
        ack_i = 0;
    endtask

    task automatic command(input logic [16:0] c, input string tag);
        scan(1, c, 17, 1, dout);
        update();
        wait_req(tag);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", req_o, 0);
        chk("rst_bus", {we_o, addr_o, wdata_o}, 0);
        chk("rst_tdo", {jtdo1_o, jtdo2_o}, 0);
        rst_i = 0;
        repeat (5) @(negedge clk);

        // 1: write, with update-to-request latency
        scan(1, 17'h1_A5_3C, 17, 1, dout);
        @(negedge clk) jupdate_i = 1;
        repeat (3) @(posedge clk);
        #1 chk("lat3", req_o, 0);
        @(posedge clk);
        #1 chk("lat4", req_o, 1);
        chk("wr_bus", {we_o, addr_o, wdata_o}, 17'h1_A5_3C);
        repeat (4) @(negedge clk);
        jupdate_i = 0;
        ack(8'h00);
        chk("wr_done", req_o, 0);

        // 2: read, then capture status
        command(17'h0_10_00, "rd_req");
        chk("rd_bus", {we_o, addr_o}, 9'h0_10);
        ack(8'h5A);
        chk("rd_done", req_o, 0);
        scan(1, 17'h0, 17, 1, dout);
        chk("rd_cap", dout, 17'h0_01_68);

        // 3: overrun
        command(17'h1_22_33, "ovr_req");
        scan(1, 17'h1_44_55, 17, 1, dout);
        update();
        chk("ovr_hold", {req_o, we_o, addr_o, wdata_o}, 18'h3_22_33);
        scan(1, 17'h0, 17, 1, dout);
        chk("ovr_cap", dout, 17'h0_01_6B);
        ack(8'h00);
        scan(1, 17'h0, 17, 1, dout);
        chk("ovr_clr", dout, 17'h0_01_68);

        // 4: TAP reset mid-shift
        command(17'h1_77_88, "trst_req");
        scan(1, 17'h1_FF_FF, 9, 1, dout);
        @(negedge clk) jrstn_i = 0;
        repeat (20) @(negedge clk);
        jrstn_i = 1;
        repeat (5) @(negedge clk);
        chk("trst_req_kept", {req_o, addr_o}, 9'h1_77);
        scan(1, 17'h0, 17, 0, dout);
        chk("trst_sr", dout, 17'h0);
        ack(8'h00);

        // 5: async reset with request pending
        command(17'h1_99_11, "arst_req");
        @(negedge clk) rst_i = 1;
        #1 chk("arst_out", {req_o, we_o, addr_o, wdata_o, jtdo1_o}, 0);
        repeat (3) @(negedge clk);
        rst_i = 0;
        repeat (5) @(negedge clk);
        chk("arst_idle", req_o, 0);
        scan(1, 17'h0, 17, 1, dout);
        chk("arst_cap", dout, 17'h0);

        // 6: ER2 status after three transactions
        for (int t = 0; t < 3; t++) begin
            command(17'h1_00_00 | 17'(t), "txn_req");
            ack(8'h00);
        end
        scan(2, 17'h0, 16, 1, dout);
`ifdef JTAG_ER2_STATUS_EN
        chk("er2_cap", dout[15:0], 16'h0300);
`else
        chk("er2_off", dout[15:0], 16'h0000);
`endif
        chk("er2_tdo", jtdo2_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
